dataram_arbiter: RTL and testbench
==================================

DATARAM_ARBITER -- requirements
Module: dataram_arbiter

Interface
REQ-001 Parameter AW, default 14, data RAM word-address width.
REQ-002 Parameter DW, default 16, data word width.
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive cycles the debug port waits while requesting before it is force-granted; legal range 1-15.
REQ-004 clock  in  1  single system clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_req  in  1  CPU requests a RAM access this cycle.
REQ-007 cpu_we  in  1  CPU access is a write (1) or a read (0).
REQ-008 cpu_addr  in  AW  CPU word address.
REQ-009 cpu_wdata  in  DW  CPU write data.
REQ-010 cpu_gnt  out  1  CPU access is performed this cycle; when low, the CPU stalls.
REQ-011 cpu_rvalid  out  1  cpu_rdata holds the result of the CPU read granted in the previous cycle.
REQ-012 cpu_rdata  out  DW  CPU read data.
REQ-013 dbg_req  in  1  debug/front-panel reader requests a read.
REQ-014 dbg_addr  in  AW  debug read address.
REQ-015 dbg_gnt  out  1  debug read is performed this cycle.
REQ-016 dbg_rvalid  out  1  dbg_rdata holds the result of the debug read granted in the previous cycle.
REQ-017 dbg_rdata  out  DW  debug read data.
REQ-018 ram_addr  out  AW  address to the SPRAM.
REQ-019 ram_din  out  DW  write data to the SPRAM.
REQ-020 ram_maskwren  out  4  nibble write mask; all four bits equal ram_wren.
REQ-021 ram_wren  out  1  SPRAM write enable.
REQ-022 ram_dout  in  DW  SPRAM read data; valid one clock after the access cycle.

Function
REQ-023 The RAM port SHALL perform at most one access per cycle; cpu_gnt and dbg_gnt SHALL never both be high.
REQ-024 force_dbg SHALL be defined as starve_cnt >= STARVE_MAX.
REQ-025 Grant logic SHALL be combinational in the same cycle:
  - cpu_gnt = cpu_req & ~(force_dbg & dbg_req)
  - dbg_gnt = dbg_req & (~cpu_req | force_dbg)
REQ-026 starve_cnt (4 bits) SHALL update as follows:
  - increment, saturating at 15, when dbg_req=1 and dbg_gnt=0;
  - clear to 0 when dbg_gnt=1 or dbg_req=0.
REQ-027 The RAM port SHALL be driven from the granted requester:
  - CPU granted: ram_addr=cpu_addr, ram_din=cpu_wdata, ram_wren=cpu_we.
  - Debug granted: ram_addr=dbg_addr, ram_din=0, ram_wren=0.
  - No grant: ram_addr=0, ram_din=0, ram_wren=0.
REQ-028 A registered owner flag SHALL record whether the current cycle's grant is a CPU read, a debug read, or neither (CPU writes record neither).
REQ-029 In the next cycle, cpu_rvalid or dbg_rvalid SHALL pulse for exactly one cycle according to the owner flag, with the matching rdata equal to ram_dout.
REQ-030 Read latency SHALL be exactly 1 cycle from grant to rvalid; back-to-back grants SHALL give back-to-back rvalid pulses.
REQ-031 A requester that is not granted SHALL hold its req, addr and data stable until granted; the arbiter SHALL NOT queue requests.
REQ-032 cpu_rdata and dbg_rdata SHALL hold their last valid value when the matching rvalid is low.
REQ-033 If dbg_req drops while the debug port is being forced, force SHALL end in the same cycle and starve_cnt SHALL clear.

Reset
REQ-034 While reset=1, the following SHALL hold:
  - cpu_gnt=0, dbg_gnt=0, ram_wren=0, ram_maskwren=0;
  - starve_cnt=0, owner=none;
  - both rvalid=0 and both rdata=0 after the reset edge.
REQ-035 Reset asserted in the cycle after a read grant SHALL suppress that read's rvalid.

Structure
REQ-036 AW, DW and the STARVE_MAX default SHALL reside in the shared package rj32_mem_pkg, which also defines the owner encoding (NONE, CPU, DBG).
REQ-037 The block SHALL be a single module with no sub-modules; the starvation counter is inline.

Verification
REQ-038 CPU write 0x1234 to address 5, then CPU read of address 5 -> cpu_gnt=1 in both cycles, ram_wren=1 only in the first, cpu_rvalid=1 with cpu_rdata=0x1234 one cycle after the read grant.
REQ-039 dbg_req alone, addr 7, RAM holding 0xBEEF -> dbg_gnt=1 the same cycle, dbg_rvalid=1 with dbg_rdata=0xBEEF the next cycle, cpu_rvalid=0 throughout.
REQ-040 cpu_req and dbg_req held continuously, STARVE_MAX=4 -> cpu_gnt for cycles 0-3, dbg_gnt in cycle 4, cpu_gnt resumes in cycle 5, pattern repeats every 5 cycles.
REQ-041 Debug forced in the same cycle as a CPU write request -> ram_wren=0, CPU write deferred one cycle, then written correctly.
REQ-042 Reset pulsed in the cycle after a CPU read grant -> no cpu_rvalid, starve_cnt=0, next grant behaves as from power-up.

Source files
------------

// File: rtl/rj32_mem_pkg.sv
// Shared memory-subsystem definitions: data RAM geometry, debug starvation limit,
// and the encoding of which requester owns the read data returning next cycle.
package rj32_mem_pkg;

    localparam int RJ32_AW         = 14;
    localparam int RJ32_DW         = 16;
    localparam int RJ32_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DBG  = 2'd2
    } owner_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

    // A CPU write produces no return data, so it leaves the read path idle.
    function automatic owner_e owner_of(input logic cpu_gnt,
                                        input logic cpu_we,
                                        input logic dbg_gnt);
        if (cpu_gnt && !cpu_we) begin
            return OWNER_CPU;
        end
        if (dbg_gnt) begin
            return OWNER_DBG;
        end
        return OWNER_NONE;
    endfunction

endpackage

// File: rtl/dataram_arbiter_if.sv
// Bundle of the CPU port, debug read port and single-port RAM connection
// that meet at the data RAM arbiter.
interface dataram_arbiter_if
    import rj32_mem_pkg::*;
#(
    parameter int AW = RJ32_AW,
    parameter int DW = RJ32_DW
);

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [3:0]    ram_maskwren;
    logic          ram_wren;
    logic [DW-1:0] ram_dout;

    // Arbiter side.
    modport slave (
        input  cpu_req,
        input  cpu_we,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_gnt,
        output cpu_rvalid,
        output cpu_rdata,
        input  dbg_req,
        input  dbg_addr,
        output dbg_gnt,
        output dbg_rvalid,
        output dbg_rdata,
        output ram_addr,
        output ram_din,
        output ram_maskwren,
        output ram_wren,
        input  ram_dout
    );

    // Requesters plus the RAM macro itself.
    modport master (
        output cpu_req,
        output cpu_we,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_gnt,
        input  cpu_rvalid,
        input  cpu_rdata,
        output dbg_req,
        output dbg_addr,
        input  dbg_gnt,
        input  dbg_rvalid,
        input  dbg_rdata,
        input  ram_addr,
        input  ram_din,
        input  ram_maskwren,
        input  ram_wren,
        output ram_dout
    );

endinterface

// File: rtl/dataram_arbiter.sv
// Shares one SPRAM between the CPU and a debug reader: CPU has priority, but a
// debug reader kept waiting STARVE_MAX cycles is force-granted for one access.
module dataram_arbiter
    import rj32_mem_pkg::*;
#(
    parameter int AW         = RJ32_AW,
    parameter int DW         = RJ32_DW,
    parameter int STARVE_MAX = RJ32_STARVE_MAX
) (
    input  logic             clock,
    input  logic             reset,
    dataram_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0]    starve_cnt;
    logic          force_dbg;
    logic          cpu_gnt;
    logic          dbg_gnt;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_wren;

    owner_e        owner_p1;
    logic          vld_cpu_p1;
    logic          vld_dbg_p1;
    logic [DW-1:0] cpu_rdata_p1;
    logic [DW-1:0] dbg_rdata_p1;

    // ---- stage p0: same-cycle grant and RAM port steering ----
    assign force_dbg = (starve_cnt >= STARVE_LIMIT);
    assign cpu_gnt   = !reset && bus.cpu_req && !(force_dbg && bus.dbg_req);
    assign dbg_gnt   = !reset && bus.dbg_req && (!bus.cpu_req || force_dbg);

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_wren = 1'b0;
        if (cpu_gnt) begin
            ram_addr = bus.cpu_addr;
            ram_din  = bus.cpu_wdata;
            ram_wren = bus.cpu_we;
        end else if (dbg_gnt) begin
            ram_addr = bus.dbg_addr;
        end
    end

    assign bus.cpu_gnt      = cpu_gnt;
    assign bus.dbg_gnt      = dbg_gnt;
    assign bus.ram_addr     = ram_addr;
    assign bus.ram_din      = ram_din;
    assign bus.ram_wren     = ram_wren;
    assign bus.ram_maskwren = {4{ram_wren}};

    // Dropping dbg_req also clears the count, so a forced grant never lingers.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (bus.dbg_req && !dbg_gnt) begin
            starve_cnt <= sat_inc4(starve_cnt);
        end else begin
            starve_cnt <= '0;
        end
    end

    // ---- stage p1: RAM data returns; route it to the owner of last cycle's read ----
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_p1 <= OWNER_NONE;
        end else begin
            owner_p1 <= owner_of(cpu_gnt, bus.cpu_we, dbg_gnt);
        end
    end

    // Reset in the return cycle cancels the pending read.
    assign vld_cpu_p1 = !reset && (owner_p1 == OWNER_CPU);
    assign vld_dbg_p1 = !reset && (owner_p1 == OWNER_DBG);

    // ram_dout is only live during the return cycle, so capture it for holding.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rdata_p1 <= '0;
            dbg_rdata_p1 <= '0;
        end else begin
            if (vld_cpu_p1) begin
                cpu_rdata_p1 <= bus.ram_dout;
            end
            if (vld_dbg_p1) begin
                dbg_rdata_p1 <= bus.ram_dout;
            end
        end
    end

    assign bus.cpu_rvalid = vld_cpu_p1;
    assign bus.dbg_rvalid = vld_dbg_p1;
    assign bus.cpu_rdata  = vld_cpu_p1 ? bus.ram_dout : cpu_rdata_p1;
    assign bus.dbg_rdata  = vld_dbg_p1 ? bus.ram_dout : dbg_rdata_p1;

`ifndef SYNTHESIS
    a_single_owner : assert property (@(posedge clock) !(cpu_gnt && dbg_gnt));
    a_mask_follows : assert property (@(posedge clock) bus.ram_maskwren == {4{ram_wren}});
    a_rvalid_mutex : assert property (@(posedge clock) !(vld_cpu_p1 && vld_dbg_p1));
`endif

endmodule

// File: tb/tb_dataram_arbiter.sv
// Scenario bench for dataram_arbiter with a behavioural SPRAM and a read-data scoreboard.
module tb_dataram_arbiter;
    import rj32_mem_pkg::*;

    localparam int AW = RJ32_AW;
    localparam int DW = RJ32_DW;
    localparam int SM = RJ32_STARVE_MAX;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] mem    [0:63];
    logic [DW-1:0] shadow [0:63];
    bit            mem_loaded = 1'b0;
    logic [DW-1:0] cpu_q [$];
    logic [DW-1:0] dbg_q [$];

    dataram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dataram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Synchronous SPRAM: read-first, data valid the cycle after the access.
    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= (i == 7) ? 16'hBEEF : DW'(32'hC000 + i * 37);
            end
            mem_loaded <= 1'b1;
        end else if (bus.ram_wren) begin
            mem[bus.ram_addr[5:0]] <= bus.ram_din;
        end
        bus.ram_dout <= mem[bus.ram_addr[5:0]];
    end

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic dr, input logic [AW-1:0] da);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.dbg_req   = dr;
        bus.dbg_addr  = da;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        next_cycle();
        next_cycle();
    endtask

    task automatic scoreboard_monitor();
        logic [DW-1:0] exp;
        forever begin
            @(negedge clock);
            if (bus.cpu_rvalid === 1'b1) begin
                compared++;
                if (cpu_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL cpu_rvalid_unexpected: got rvalid=1 rdata=%h, required rvalid=0 @%0t", bus.cpu_rdata, $time);
                end else begin
                    exp = cpu_q.pop_front();
                    if (bus.cpu_rdata !== exp) begin
                        mismatched++;
                        $display("FAIL cpu_rdata: got %h, required %h @%0t", bus.cpu_rdata, exp, $time);
                    end
                end
            end
            if (bus.dbg_rvalid === 1'b1) begin
                compared++;
                if (dbg_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL dbg_rvalid_unexpected: got rvalid=1 rdata=%h, required rvalid=0 @%0t", bus.dbg_rdata, $time);
                end else begin
                    exp = dbg_q.pop_front();
                    if (bus.dbg_rdata !== exp) begin
                        mismatched++;
                        $display("FAIL dbg_rdata: got %h, required %h @%0t", bus.dbg_rdata, exp, $time);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, AW'(5), 16'hFFFF, 1'b1, AW'(7));
        next_cycle();
        next_cycle();
        @(negedge clock);
        compared++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren, bus.ram_maskwren} !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got gnt/wren/mask %b, required 0000000",
                     {bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren, bus.ram_maskwren});
        end
        compared++;
        if ({bus.cpu_rvalid, bus.dbg_rvalid} !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_rvalid: got %b, required 00", {bus.cpu_rvalid, bus.dbg_rvalid});
        end
        compared++;
        if ({bus.cpu_rdata, bus.dbg_rdata} !== '0) begin
            mismatched++;
            $display("FAIL reset_rdata: got %h/%h, required 0/0", bus.cpu_rdata, bus.dbg_rdata);
        end
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_cpu_write_read();
        drive(1'b1, 1'b1, AW'(5), 16'h1234, 1'b0, '0);
        @(negedge clock);
        compared++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren, bus.ram_maskwren} !== 7'b1011111) begin
            mismatched++;
            $display("FAIL wr_ctrl: got %b, required 1011111",
                     {bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren, bus.ram_maskwren});
        end
        compared++;
        if (bus.ram_addr !== AW'(5) || bus.ram_din !== 16'h1234) begin
            mismatched++;
            $display("FAIL wr_port: got addr=%h din=%h, required addr=0005 din=1234", bus.ram_addr, bus.ram_din);
        end
        shadow[5] = 16'h1234;
        next_cycle();
        drive(1'b1, 1'b0, AW'(5), 16'h7777, 1'b0, '0);
        @(negedge clock);
        compared++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren, bus.ram_maskwren} !== 7'b1000000
            || bus.ram_addr !== AW'(5) || bus.ram_din !== 16'h7777) begin
            mismatched++;
            $display("FAIL rd_ctrl: got %b addr=%h din=%h, required 1000000 addr=0005 din=7777",
                     {bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren, bus.ram_maskwren}, bus.ram_addr, bus.ram_din);
        end
        cpu_q.push_back(shadow[5]);
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clock);
        compared++;
        if (bus.cpu_rvalid !== 1'b1 || {bus.ram_addr, bus.ram_din, bus.cpu_gnt} !== '0) begin
            mismatched++;
            $display("FAIL rd_return: got rvalid=%b addr=%h din=%h gnt=%b, required rvalid=1 addr/din/gnt=0",
                     bus.cpu_rvalid, bus.ram_addr, bus.ram_din, bus.cpu_gnt);
        end
        next_cycle();
        @(negedge clock);
        compared++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 16'h1234) begin
            mismatched++;
            $display("FAIL rd_hold: got rvalid=%b rdata=%h, required rvalid=0 rdata=1234", bus.cpu_rvalid, bus.cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_dbg_read();
        drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(7));
        @(negedge clock);
        compared++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren} !== 3'b010
            || bus.ram_addr !== AW'(7) || bus.ram_din !== '0) begin
            mismatched++;
            $display("FAIL dbg_grant: got %b addr=%h din=%h, required 010 addr=0007 din=0",
                     {bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren}, bus.ram_addr, bus.ram_din);
        end
        dbg_q.push_back(shadow[7]);
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clock);
        compared++;
        if ({bus.cpu_rvalid, bus.dbg_rvalid} !== 2'b01) begin
            mismatched++;
            $display("FAIL dbg_return: got cpu/dbg rvalid %b, required 01", {bus.cpu_rvalid, bus.dbg_rvalid});
        end
        next_cycle();
        @(negedge clock);
        compared++;
        if ({bus.cpu_rvalid, bus.dbg_rvalid} !== 2'b00 || bus.dbg_rdata !== 16'hBEEF) begin
            mismatched++;
            $display("FAIL dbg_hold: got rvalid %b rdata=%h, required 00 rdata=beef",
                     {bus.cpu_rvalid, bus.dbg_rvalid}, bus.dbg_rdata);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic exp_dbg;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, AW'(3), '0, 1'b1, AW'(9));
            exp_dbg = ((i % 5) == 4);
            @(negedge clock);
            compared++;
            if ({bus.cpu_gnt, bus.dbg_gnt} !== {!exp_dbg, exp_dbg}
                || bus.ram_addr !== (exp_dbg ? AW'(9) : AW'(3))) begin
                mismatched++;
                $display("FAIL starve_cycle%0d: got gnt %b addr=%h, required %b addr=%h", i,
                         {bus.cpu_gnt, bus.dbg_gnt}, bus.ram_addr, {!exp_dbg, exp_dbg}, exp_dbg ? AW'(9) : AW'(3));
            end
            if (exp_dbg) dbg_q.push_back(shadow[9]);
            else         cpu_q.push_back(shadow[3]);
            next_cycle();
        end
        drain();
    endtask

    task automatic test_force_vs_write();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, AW'(3), '0, 1'b1, AW'(9));
            @(negedge clock);
            compared++;
            if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b10) begin
                mismatched++;
                $display("FAIL fw_pre%0d: got %b, required 10", i, {bus.cpu_gnt, bus.dbg_gnt});
            end
            cpu_q.push_back(shadow[3]);
            next_cycle();
        end
        drive(1'b1, 1'b1, AW'(20), 16'h5A5A, 1'b1, AW'(9));
        @(negedge clock);
        compared++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren, bus.ram_maskwren} !== 7'b0100000) begin
            mismatched++;
            $display("FAIL fw_forced: got %b, required 0100000",
                     {bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren, bus.ram_maskwren});
        end
        dbg_q.push_back(shadow[9]);
        next_cycle();
        drive(1'b1, 1'b1, AW'(20), 16'h5A5A, 1'b0, '0);
        @(negedge clock);
        compared++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren} !== 3'b101
            || bus.ram_addr !== AW'(20) || bus.ram_din !== 16'h5A5A) begin
            mismatched++;
            $display("FAIL fw_deferred: got %b addr=%h din=%h, required 101 addr=0014 din=5a5a",
                     {bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren}, bus.ram_addr, bus.ram_din);
        end
        shadow[20] = 16'h5A5A;
        next_cycle();
        drive(1'b1, 1'b0, AW'(20), '0, 1'b0, '0);
        @(negedge clock);
        cpu_q.push_back(shadow[20]);
        next_cycle();
        drain();
    endtask

    task automatic test_dbg_drop();
        logic exp_dbg;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, AW'(3), '0, (i != 4), AW'(11));
            exp_dbg = (i == 9);
            @(negedge clock);
            compared++;
            if ({bus.cpu_gnt, bus.dbg_gnt} !== {!exp_dbg, exp_dbg}) begin
                mismatched++;
                $display("FAIL drop_cycle%0d: got %b, required %b", i, {bus.cpu_gnt, bus.dbg_gnt}, {!exp_dbg, exp_dbg});
            end
            if (exp_dbg) dbg_q.push_back(shadow[11]);
            else         cpu_q.push_back(shadow[3]);
            next_cycle();
        end
        drain();
    endtask

    task automatic test_reset_after_read();
        logic exp_dbg;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, AW'(5), '0, 1'b1, AW'(12));
            @(negedge clock);
            compared++;
            if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b10) begin
                mismatched++;
                $display("FAIL rst_pre%0d: got %b, required 10", i, {bus.cpu_gnt, bus.dbg_gnt});
            end
            if (i < 2) cpu_q.push_back(shadow[5]);
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clock);
        compared++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid} !== 4'b0000) begin
            mismatched++;
            $display("FAIL rst_suppress: got gnt/rvalid %b, required 0000",
                     {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid});
        end
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_dbg = (i == SM);
            @(negedge clock);
            compared++;
            if ({bus.cpu_gnt, bus.dbg_gnt} !== {!exp_dbg, exp_dbg}) begin
                mismatched++;
                $display("FAIL rst_post%0d: got %b, required %b", i, {bus.cpu_gnt, bus.dbg_gnt}, {!exp_dbg, exp_dbg});
            end
            if (i == 0) begin
                compared++;
                if ({bus.cpu_rvalid, bus.cpu_rdata, bus.dbg_rdata} !== '0) begin
                    mismatched++;
                    $display("FAIL rst_rdata_clear: got rvalid=%b cpu=%h dbg=%h, required 0/0/0",
                             bus.cpu_rvalid, bus.cpu_rdata, bus.dbg_rdata);
                end
            end
            if (exp_dbg) dbg_q.push_back(shadow[12]);
            else         cpu_q.push_back(shadow[5]);
            next_cycle();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic cr, cw, dr, fd, eg_c, eg_d, pend_c, pend_d;
        logic [AW-1:0] ca, da, exp_addr;
        logic [DW-1:0] cd;
        int mcnt;
        pend_c = 1'b0;
        pend_d = 1'b0;
        mcnt = 0;
        cr = 1'b0; cw = 1'b0; dr = 1'b0; ca = '0; da = '0; cd = '0;
        for (int i = 0; i < 80; i++) begin
            if (!pend_c) begin
                cr = ($urandom_range(0, 3) != 0);
                cw = ($urandom_range(0, 2) == 0);
                ca = AW'($urandom_range(0, 31));
                cd = DW'($urandom);
            end
            if (!pend_d) begin
                dr = ($urandom_range(0, 1) == 1);
                da = AW'($urandom_range(0, 31));
            end
            drive(cr, cw, ca, cd, dr, da);
            fd = (mcnt >= SM);
            eg_c = cr && !(fd && dr);
            eg_d = dr && (!cr || fd);
            exp_addr = eg_c ? ca : (eg_d ? da : '0);
            @(negedge clock);
            compared++;
            if ({bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren} !== {eg_c, eg_d, eg_c && cw}
                || bus.ram_addr !== exp_addr) begin
                mismatched++;
                $display("FAIL b2b_cycle%0d: got gnt/wren %b addr=%h, required %b addr=%h", i,
                         {bus.cpu_gnt, bus.dbg_gnt, bus.ram_wren}, bus.ram_addr, {eg_c, eg_d, eg_c && cw}, exp_addr);
            end
            if (eg_c && cw)  shadow[ca[5:0]] = cd;
            if (eg_c && !cw) cpu_q.push_back(shadow[ca[5:0]]);
            if (eg_d)        dbg_q.push_back(shadow[da[5:0]]);
            mcnt = (dr && !eg_d) ? ((mcnt < 15) ? mcnt + 1 : 15) : 0;
            pend_c = cr && !eg_c;
            pend_d = dr && !eg_d;
            next_cycle();
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            shadow[i] = (i == 7) ? 16'hBEEF : DW'(32'hC000 + i * 37);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_cpu_write_read();
        test_dbg_read();
        test_starvation();
        test_force_vs_write();
        test_dbg_drop();
        test_reset_after_read();
        test_back_to_back();
        @(negedge clock);
        #1;
        compared++;
        if (cpu_q.size() != 0 || dbg_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_rvalid: got %0d cpu / %0d dbg reads outstanding, required 0/0",
                     cpu_q.size(), dbg_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
